multdiv_issue_ctrl: RTL and testbench
=====================================

MULTDIV_ISSUE_CTRL -- requirements
Module: multdiv_issue_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 63, meaning the max BUSY/ABORT cycles before err_o is set.
REQ-002 SHALL have port clk_i  in  1  clock, all flops rising-edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i/req_ready_o  in/out  1/1  upstream request handshake.
REQ-005 SHALL have port req_op_i  in  2  operation: 0 MULL, 1 MULH, 2 DIV, 3 REM.
REQ-006 SHALL have port req_signed_i  in  2  bit0 = op A signed, bit1 = op B signed.
REQ-007 SHALL have ports req_op_a_i, req_op_b_i  in  32 each  operands.
REQ-008 SHALL have port req_tag_i  in  5  destination tag, returned with the result.
REQ-009 SHALL have port kill_i  in  1  flush; abandons any in-flight or pending result.
REQ-010 SHALL have ports mult_en_o, div_en_o, mult_sel_o, div_sel_o  out  1 each  unit enables/selects.
REQ-011 SHALL have ports operator_o  out  2,  signed_mode_o  out  2,  op_a_o/op_b_o  out  32  unit operands.
REQ-012 SHALL have ports imd_val_d_i  in  68,  imd_val_we_i  in  2,  imd_val_q_o  out  68  intermediate storage.
REQ-013 SHALL have ports valid_i  in  1,  multdiv_result_i  in  32,  multdiv_ready_id_o  out  1  unit completion.
REQ-014 SHALL have ports rsp_valid_o/rsp_ready_i  out/in  1/1,  rsp_result_o  out  32,  rsp_tag_o  out  5.
REQ-015 SHALL have port err_o  out  1  sticky watchdog error.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP, ABORT.
REQ-017 SHALL assert req_ready_o in IDLE, and in RESP when rsp_ready_i=1, in both cases only when kill_i=0.
REQ-018 SHALL, on req_valid_i & req_ready_o, register op, signed, operands and tag, and enter BUSY next cycle.
REQ-019 SHALL hold op_a_o, op_b_o, operator_o, signed_mode_o stable from these registers during BUSY and ABORT.
REQ-020 SHALL, in BUSY/ABORT, drive mult_en_o=mult_sel_o=(op<=1) and div_en_o=div_sel_o=(op>=2); all four SHALL be 0 in IDLE/RESP.
REQ-021 SHALL drive multdiv_ready_id_o=1 in BUSY/ABORT and 0 otherwise, so the unit never holds at completion.
REQ-022 SHALL, on valid_i=1 in BUSY with kill_i=0, capture multdiv_result_i into rsp_result_o and enter RESP.
REQ-023 SHALL, in RESP, assert rsp_valid_o with rsp_result_o and rsp_tag_o held stable until rsp_ready_i=1.
REQ-024 SHALL, on an RESP handshake, go to BUSY if a new request is accepted in the same cycle, else to IDLE.
REQ-025 SHALL, on kill_i in BUSY with valid_i=0, enter ABORT.
REQ-026 SHALL, on kill_i in BUSY with valid_i=1, go to IDLE and discard the result.
REQ-027 SHALL, in ABORT, keep the unit enabled until valid_i=1, then go to IDLE with no response, so the unit returns to its idle state.
REQ-028 SHALL, on kill_i in RESP, drop rsp_valid_o next cycle and go to IDLE.
REQ-029 SHALL treat kill_i in IDLE or ABORT as having no further effect.
REQ-030 SHALL keep two 34-bit registers, imd_val_q_o[33:0] and [67:34]; bit k of imd_val_we_i loads slice k from imd_val_d_i at the clock edge, in any state.
REQ-031 SHALL count consecutive BUSY/ABORT cycles in a 7-bit counter, cleared on entry to BUSY/ABORT and saturating at 127.
REQ-032 SHALL set err_o when the counter exceeds WDOG_LIMIT; err_o SHALL remain set until reset and SHALL NOT alter the FSM.
REQ-033 SHALL provide latency as follows: accept at cycle T, BUSY from T+1, and rsp_valid_o at the cycle after valid_i.

Reset
REQ-034 SHALL, on reset, clear all of the following:
- FSM to IDLE
- operand, tag and result registers to 0
- imd_val registers to 0
- counter and err_o to 0
REQ-035 SHALL, on reset, drive all outputs to 0 except req_ready_o=1.
REQ-036 SHALL, on reset asserted mid-BUSY, abandon the operation with no response after deassertion.

Verification (bench connects the team's slow multdiv unit)
REQ-037 SHALL cover MULL signed=00, A=7, B=6 -> rsp_valid_o with result 0x0000002A, tag echoed, and rsp_valid_o within 36 cycles of accept.
REQ-038 SHALL cover DIV signed=11, A=0xFFFFFFF9, B=2 -> result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-039 SHALL cover DIV with B=0, A=5 -> result 0xFFFFFFFF; REM -> 0x00000005.
REQ-040 SHALL cover rsp_ready_i low for 5 cycles in RESP -> rsp_valid_o, result and tag stable for 5 cycles; a back-to-back request on the handshake cycle is accepted and reaches BUSY next cycle.
REQ-041 SHALL cover kill_i 3 cycles after a DIV accept -> ABORT, no rsp_valid_o, and IDLE after valid_i; a following MULL 3*3 then returns 0x00000009.
REQ-042 SHALL cover a stub that never raises valid_i -> err_o=1 on cycle 64 of BUSY and stays 1; rst_ni pulse -> err_o=0, IDLE, req_ready_o=1.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_issue_ctrl
// Issues one multiply/divide op at a time to the shared multdiv unit and
// returns its tagged result through a valid/ready response port.
// Rev     : 1.0  initial release
// ============================================================================
module multdiv_issue_ctrl #(
  parameter int unsigned WDOG_LIMIT = 63
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // upstream request
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [1:0]  req_signed_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic [4:0]  req_tag_i,
  input  logic        kill_i,
  // multdiv unit side
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  input  logic [67:0] imd_val_d_i,
  input  logic [1:0]  imd_val_we_i,
  output logic [67:0] imd_val_q_o,
  input  logic        valid_i,
  input  logic [31:0] multdiv_result_i,
  output logic        multdiv_ready_id_o,
  // response
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [4:0]  rsp_tag_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  signed_q, signed_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  tag_q, tag_d;
  logic [31:0] result_q, result_d;
  logic [33:0] imd_lo_q, imd_lo_d;
  logic [33:0] imd_hi_q, imd_hi_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        req_ready;
  logic        accept;
  logic        unit_active;
  logic        unit_active_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    signed_d = signed_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    tag_d    = tag_q;
    result_d = result_q;
    imd_lo_d = imd_lo_q;
    imd_hi_d = imd_hi_q;
    cnt_d    = 7'd0;
    err_d    = err_q;

    unit_active = (state_q == BUSY) || (state_q == ABORT);

    req_ready = 1'b0;
    if (!kill_i) begin
      if (state_q == IDLE) begin
        req_ready = 1'b1;
      end else if ((state_q == RESP) && rsp_ready_i) begin
        req_ready = 1'b1;
      end
    end
    accept = req_valid_i && req_ready;

    case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        // a completion coinciding with a flush is simply dropped
        if (kill_i) begin
          state_d = valid_i ? IDLE : ABORT;
        end else if (valid_i) begin
          result_d = multdiv_result_i;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (rsp_ready_i) begin
          state_d = accept ? BUSY : IDLE;
        end
      end
      ABORT: begin
        // keep the unit running until it reports done so it re-enters its idle state
        if (valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d     = req_op_i;
      signed_d = req_signed_i;
      op_a_d   = req_op_a_i;
      op_b_d   = req_op_b_i;
      tag_d    = req_tag_i;
    end

    if (imd_val_we_i[0]) imd_lo_d = imd_val_d_i[33:0];
    if (imd_val_we_i[1]) imd_hi_d = imd_val_d_i[67:34];

    // counter restarts whenever BUSY/ABORT is entered from IDLE or RESP
    unit_active_d = (state_d == BUSY) || (state_d == ABORT);
    if (unit_active_d && unit_active) begin
      cnt_d = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;
    end
    err_d = err_q || (unit_active_d && (32'(cnt_d) > WDOG_LIMIT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      signed_q <= 2'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      tag_q    <= 5'd0;
      result_q <= 32'd0;
      imd_lo_q <= 34'd0;
      imd_hi_q <= 34'd0;
      cnt_q    <= 7'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      imd_lo_q <= imd_lo_d;
      imd_hi_q <= imd_hi_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o        = req_ready;
  assign mult_en_o          = unit_active && (op_q <= 2'd1);
  assign mult_sel_o         = unit_active && (op_q <= 2'd1);
  assign div_en_o           = unit_active && (op_q >= 2'd2);
  assign div_sel_o          = unit_active && (op_q >= 2'd2);
  assign multdiv_ready_id_o = unit_active;
  assign operator_o         = op_q;
  assign signed_mode_o      = signed_q;
  assign op_a_o             = op_a_q;
  assign op_b_o             = op_b_q;
  assign imd_val_q_o        = {imd_hi_q, imd_lo_q};
  assign rsp_valid_o        = (state_q == RESP);
  assign rsp_result_o       = result_q;
  assign rsp_tag_o          = tag_q;
  assign err_o              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_multdiv_issue_ctrl
// Bench for multdiv_issue_ctrl with a behavioural slow multdiv unit.
// Rev     : 1.0  initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

  localparam int WDOG  = 63;
  localparam int L_MUL = 4;
  localparam int L_DIV = 33;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 2'd0;
  logic [1:0]  req_signed_i = 2'd0;
  logic [31:0] req_op_a_i = 32'd0;
  logic [31:0] req_op_b_i = 32'd0;
  logic [4:0]  req_tag_i = 5'd0;
  logic        kill_i = 1'b0;
  logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic [1:0]  operator_o, signed_mode_o;
  logic [31:0] op_a_o, op_b_o;
  logic [67:0] imd_val_d_i = 68'd0;
  logic [1:0]  imd_val_we_i = 2'd0;
  logic [67:0] imd_val_q_o;
  logic        valid_i = 1'b0;
  logic [31:0] multdiv_result_i = 32'd0;
  logic        multdiv_ready_id_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_tag_o;
  logic        err_o;

  multdiv_issue_ctrl #(.WDOG_LIMIT(WDOG)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_signed_i(req_signed_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_tag_i(req_tag_i),
    .kill_i(kill_i),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o),
    .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
    .operator_o(operator_o), .signed_mode_o(signed_mode_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o),
    .imd_val_d_i(imd_val_d_i), .imd_val_we_i(imd_val_we_i), .imd_val_q_o(imd_val_q_o),
    .valid_i(valid_i), .multdiv_result_i(multdiv_result_i),
    .multdiv_ready_id_o(multdiv_ready_id_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural mult/div result: op 0 MULL, 1 MULH, 2 DIV, 3 REM
  function automatic logic [31:0] ref_calc(input logic [1:0] op, input logic [1:0] sgn,
                                           input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] t;
    sa = sgn[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn[1] ? longint'($signed(b)) : longint'({32'd0, b});
    if (op == 2'd0 || op == 2'd1) begin
      t = sa * sb;
      return (op == 2'd0) ? t[31:0] : t[63:32];
    end else if (b == 32'd0) begin
      return (op == 2'd2) ? 32'hFFFF_FFFF : a;
    end else begin
      t = (op == 2'd2) ? (sa / sb) : (sa % sb);
      return t[31:0];
    end
  endfunction

  // Slow unit: raises valid_i for one cycle after a fixed number of enabled cycles
  int ucnt = 0;
  bit stub_hang = 1'b0;
  always begin
    @(posedge clk_i);
    #1;
    if (!rst_ni || !(mult_en_o || div_en_o)) begin
      ucnt = 0;
      valid_i = 1'b0;
      multdiv_result_i = 32'd0;
    end else begin
      ucnt++;
      valid_i = !stub_hang && (ucnt == (div_en_o ? L_DIV : L_MUL));
      multdiv_result_i = valid_i ? ref_calc(operator_o, signed_mode_o, op_a_o, op_b_o) : 32'd0;
    end
  end

  // Transaction-level model: one operation owned by the unit, at most one result waiting
  bit          m_inflight = 0;
  bit          m_flushed  = 0;
  bit          m_have_rsp = 0;
  logic [1:0]  m_op = 0, m_sgn = 0;
  logic [31:0] m_a = 0, m_b = 0, m_res = 0;
  logic [4:0]  m_tag = 0, m_rtag = 0;
  int          m_run = 0;
  bit          m_err = 0;
  logic [67:0] m_imd = 0;

  always @(negedge clk_i) begin
    bit exp_ready, accept, was_inflight, is_mul;
    if (!rst_ni) begin
      m_inflight = 0; m_flushed = 0; m_have_rsp = 0; m_run = 0; m_err = 0; m_imd = '0;
      chk("reset_ctl",
          {req_ready_o, rsp_valid_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o,
           multdiv_ready_id_o, err_o, operator_o, signed_mode_o},
          {1'b1, 11'd0});
      chk("reset_ops", {op_a_o, op_b_o}, 68'd0);
      chk("reset_rsp", {rsp_result_o, rsp_tag_o}, 68'd0);
      chk("reset_imd", imd_val_q_o, 68'd0);
    end else begin
      exp_ready = !kill_i && !m_inflight && (!m_have_rsp || rsp_ready_i);
      is_mul    = (m_op < 2'd2);
      chk("req_ready", req_ready_o, exp_ready);
      chk("rsp_valid", rsp_valid_o, m_have_rsp);
      if (m_have_rsp) chk("rsp_data", {rsp_result_o, rsp_tag_o}, {m_res, m_rtag});
      chk("unit_ctl", {multdiv_ready_id_o, mult_en_o, mult_sel_o, div_en_o, div_sel_o},
          {m_inflight, m_inflight && is_mul, m_inflight && is_mul,
           m_inflight && !is_mul, m_inflight && !is_mul});
      if (m_inflight) chk("unit_ops", {operator_o, signed_mode_o, op_a_o, op_b_o}, {m_op, m_sgn, m_a, m_b});
      chk("err", err_o, m_err);
      chk("imd", imd_val_q_o, m_imd);

      accept       = req_valid_i && exp_ready;
      was_inflight = m_inflight;
      if (m_have_rsp && (kill_i || rsp_ready_i)) begin
        m_have_rsp = 0;
      end else if (m_inflight) begin
        if (valid_i) begin
          m_inflight = 0;
          if (!m_flushed && !kill_i) begin
            m_have_rsp = 1;
            m_res      = ref_calc(m_op, m_sgn, m_a, m_b);
            m_rtag     = m_tag;
          end
        end else if (kill_i) begin
          m_flushed = 1;
        end
      end
      if (accept) begin
        m_inflight = 1; m_flushed = 0; m_run = 0;
        m_op = req_op_i; m_sgn = req_signed_i; m_a = req_op_a_i; m_b = req_op_b_i; m_tag = req_tag_i;
      end else if (was_inflight && m_inflight) begin
        m_run++;
      end
      if (m_inflight && !accept && m_run > WDOG) m_err = 1;
      if (accept && was_inflight) m_err = m_err;
      if (imd_val_we_i[0]) m_imd[33:0]  = imd_val_d_i[33:0];
      if (imd_val_we_i[1]) m_imd[67:34] = imd_val_d_i[67:34];
    end
  end

  // Stimulus tasks start and end just after a rising edge
  task automatic do_req(input logic [1:0] op, input logic [1:0] sgn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bit ok = 0;
    req_op_i = op; req_signed_i = sgn; req_op_a_i = a; req_op_b_i = b; req_tag_i = tag;
    req_valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_i);
      if (req_ready_o) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: got no req_ready_o expected accept");
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] res, output logic [4:0] tag, output int lat);
    bit seen = 0;
    lat = 0; res = '0; tag = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      lat++;
      if (rsp_valid_o) begin
        seen = 1; res = rsp_result_o; tag = rsp_tag_o;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid_o expected response");
    end
    @(posedge clk_i); #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] sgn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res);
    logic [31:0] res; logic [4:0] rtag; int lat;
    do_req(op, sgn, a, b, tag);
    wait_rsp(res, rtag, lat);
    chk({name, "_result"}, res, exp_res);
    chk({name, "_tag"}, rtag, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] res, res0;
    logic [4:0]  rtag, tag0;
    logic [67:0] d1, d2;
    int          lat, cnt;

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_reset_ready", {req_ready_o, rsp_valid_o, multdiv_ready_id_o, err_o}, 4'b1000);
    @(posedge clk_i); #1;

    // MULL 7*6 with latency measured from the accept cycle
    do_req(2'd0, 2'b00, 32'd7, 32'd6, 5'd3);
    wait_rsp(res, rtag, lat);
    chk("mull_result", res, 32'h0000_002A);
    chk("mull_tag", rtag, 5'd3);
    chk("mull_latency", lat, L_MUL + 1);
    chk("mull_latency_le36", lat <= 36, 1'b1);

    run_op("mulh_ss", 2'd1, 2'b11, 32'hFFFF_FFFE, 32'd3, 5'd4, 32'hFFFF_FFFF);
    run_op("mulh_uu", 2'd1, 2'b00, 32'hFFFF_FFFE, 32'd3, 5'd5, 32'h0000_0002);

    do_req(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_rsp(res, rtag, lat);
    chk("div_s_result", res, 32'hFFFF_FFFD);
    chk("div_latency_le36", lat <= 36, 1'b1);
    run_op("rem_s", 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
    run_op("div_by0", 2'd2, 2'b00, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
    run_op("rem_by0", 2'd3, 2'b00, 32'd5, 32'd0, 5'd9, 32'h0000_0005);

    // response back-pressure, then back-to-back request on the handshake
    rsp_ready_i = 1'b0;
    do_req(2'd0, 2'b00, 32'd5, 32'd5, 5'd17);
    wait_rsp(res0, tag0, lat);
    chk("bp_first_result", {res0, tag0}, {32'd25, 5'd17});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_stable", {rsp_valid_o, rsp_result_o, rsp_tag_o}, {1'b1, 32'd25, 5'd17});
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1'b1;
    req_op_i = 2'd0; req_signed_i = 2'b00; req_op_a_i = 32'd2; req_op_b_i = 32'd8; req_tag_i = 5'd10;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    chk("b2b_ready", {req_ready_o, rsp_valid_o}, 2'b11);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_busy", {multdiv_ready_id_o, mult_en_o, rsp_valid_o}, 3'b110);
    @(posedge clk_i); #1;
    wait_rsp(res, rtag, lat);
    chk("b2b_result", {res, rtag}, {32'd16, 5'd10});

    // kill three cycles after a DIV accept
    do_req(2'd2, 2'b11, 32'd100, 32'd7, 5'd11);
    repeat (2) begin @(posedge clk_i); #1; end
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    cnt = 0; lat = 0;
    for (int i = 0; i < 60 && !req_ready_o; i++) begin
      @(negedge clk_i);
      if (multdiv_ready_id_o) cnt++;
      if (rsp_valid_o) lat++;
      if (!req_ready_o) begin @(posedge clk_i); #1; end
    end
    chk("abort_cycles", cnt, 30);
    chk("abort_no_rsp", lat, 0);
    chk("abort_to_idle", req_ready_o, 1'b1);
    @(posedge clk_i); #1;
    run_op("after_abort", 2'd0, 2'b00, 32'd3, 32'd3, 5'd12, 32'h0000_0009);

    // kill while a response is waiting
    rsp_ready_i = 1'b0;
    do_req(2'd0, 2'b00, 32'd4, 32'd4, 5'd13);
    wait_rsp(res, rtag, lat);
    kill_i = 1'b1;
    @(negedge clk_i);
    chk("kill_resp_ready", {req_ready_o, rsp_valid_o}, 2'b01);
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("kill_resp_drop", {req_ready_o, rsp_valid_o}, 2'b10);
    @(posedge clk_i); #1;

    // intermediate storage slices
    d1 = {4'hA, 32'h1234_5678, 32'h9ABC_DEF0};
    d2 = {4'h5, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
    imd_val_d_i = d1; imd_val_we_i = 2'b01;
    @(posedge clk_i); #1;
    imd_val_d_i = d2; imd_val_we_i = 2'b10;
    @(posedge clk_i); #1;
    imd_val_we_i = 2'b00; imd_val_d_i = '1;
    @(negedge clk_i);
    chk("imd_slices", imd_val_q_o, {d2[67:34], d1[33:0]});
    @(posedge clk_i); #1;

    // watchdog on a unit that never completes, then reset mid-BUSY
    stub_hang = 1'b1;
    do_req(2'd2, 2'b00, 32'd1, 32'd1, 5'd14);
    for (int i = 0; i <= 70; i++) begin
      @(negedge clk_i);
      if (i == 62 || i == 63 || i == 64 || i == 65 || i == 70)
        chk($sformatf("wdog_cycle%0d", i), {err_o, multdiv_ready_id_o}, {(i >= 64), 1'b1});
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    stub_hang = 1'b0;
    @(negedge clk_i);
    chk("wdog_after_reset", {err_o, req_ready_o, multdiv_ready_id_o}, 3'b010);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) lat++;
    end
    chk("reset_busy_no_rsp", lat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
